// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 general register file.
// Forms the writeback value (ALU, extended load data, or link address), commits
// it on the rising edge, serves two bypassed read ports, and counts retired
// instructions and committed writes for debug.
module wb_regfile #(
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [29:0]      fourPC,
  input  logic [1:0]       memToReg,
  input  logic [31:0]      aluResult,
  input  logic [31:0]      readData,
  input  logic [4:0]       writeDataReg,
  input  logic             regWrite,
  input  logic [31:0]      instruction,
  input  logic [4:0]       readReg1,
  input  logic [4:0]       readReg2,
  output logic [31:0]      readData1,
  output logic [31:0]      readData2,
  output logic [31:0]      wbData,
  output logic             wbWe,
  output logic [CNT_W-1:0] retireCount,
  output logic [CNT_W-1:0] writeCount
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  logic [31:0]      gpr_r [0:31];
  logic [CNT_W-1:0] retire_cnt_r;
  logic [CNT_W-1:0] write_cnt_r;
  logic             wb_we_s;
  logic [31:0]      wb_data_s;

  // Sub-word load extension: picks the little-endian lane by byte offset and
  // sign/zero extends according to the load opcode; full word otherwise.
  function automatic logic [31:0] load_ext(input logic [5:0]  op,
                                           input logic [1:0]  off,
                                           input logic [31:0] word);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] res;
    case (off)
      2'd0:    lane_b = word[7:0];
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    if (off[1]) begin
      lane_h = word[31:16];
    end else begin
      lane_h = word[15:0];
    end
    case (op)
      OP_LB:   res = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  res = {24'd0, lane_b};
      OP_LH:   res = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  res = {16'd0, lane_h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Writeback value select and effective write enable ($0 writes suppressed).
  always_comb begin
    wb_data_s = aluResult;
    case (memToReg)
      2'b01:   wb_data_s = load_ext(instruction[31:26], aluResult[1:0], readData);
      2'b10:   wb_data_s = {fourPC, 2'b00};
      default: wb_data_s = aluResult;
    endcase
    wb_we_s = regWrite && (writeDataReg != 5'd0);
  end

  // GPR array: cleared on reset, written with the writeback value when enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        gpr_r[i] <= 32'd0;
      end
    end else if (wb_we_s) begin
      gpr_r[writeDataReg] <= wb_data_s;
    end
  end

  // Debug counters: non-bubble retirements and committed GPR writes, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retire_cnt_r <= {CNT_W{1'b0}};
      write_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (instruction != 32'd0) begin
        retire_cnt_r <= retire_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (wb_we_s) begin
        write_cnt_r <= write_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Read ports: $0 reads zero, a matching in-flight write is bypassed when enabled.
  always_comb begin
    if (readReg1 == 5'd0) begin
      readData1 = 32'd0;
    end else if (BYPASS_EN && wb_we_s && (readReg1 == writeDataReg)) begin
      readData1 = wb_data_s;
    end else begin
      readData1 = gpr_r[readReg1];
    end
    if (readReg2 == 5'd0) begin
      readData2 = 32'd0;
    end else if (BYPASS_EN && wb_we_s && (readReg2 == writeDataReg)) begin
      readData2 = wb_data_s;
    end else begin
      readData2 = gpr_r[readReg2];
    end
  end

  assign wbData      = wb_data_s;
  assign wbWe        = wb_we_s;
  assign retireCount = retire_cnt_r;
  assign writeCount  = write_cnt_r;

endmodule
